// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: serial-unit FSM encodings and a width helper.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } serial_state_t;

    // Counter width for an n-step sequence; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor, LSB first, with start/busy/done handshake.
module serial_subtractor_nbit
    import arith_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         borrow_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow_out,
    output logic         overflow
);

    localparam int CNT_W = clog2_min1(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    serial_state_t    state_reg;
    logic [N-1:0]     a_sh_reg;
    logic [N-1:0]     b_sh_reg;
    logic [N-1:0]     res_sh_reg;
    logic [N-1:0]     res_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             br_reg;
    logic             br_next;
    logic             d_bit;
    logic             a_msb_reg;
    logic             b_msb_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [N-1:0]     diff_reg;
    logic             borrow_out_reg;
    logic             overflow_reg;

    full_subtractor u_fs (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .bin  (br_reg),
        .d    (d_bit),
        .bout (br_next)
    );

    assign res_next = {d_bit, res_sh_reg[N-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            a_sh_reg       <= '0;
            b_sh_reg       <= '0;
            res_sh_reg     <= '0;
            cnt_reg        <= '0;
            br_reg         <= 1'b0;
            a_msb_reg      <= 1'b0;
            b_msb_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            diff_reg       <= '0;
            borrow_out_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_sh_reg  <= A;
                        b_sh_reg  <= B;
                        br_reg    <= borrow_in;
                        a_msb_reg <= A[N-1];
                        b_msb_reg <= B[N-1];
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= SHIFT;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    res_sh_reg <= res_next;
                    br_reg     <= br_next;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        // Signed overflow uses the original operand MSBs, which have shifted out by now.
                        diff_reg       <= res_next;
                        borrow_out_reg <= br_next;
                        overflow_reg   <= (a_msb_reg ^ b_msb_reg) & (a_msb_reg ^ d_bit);
                        busy_reg       <= 1'b0;
                        done_reg       <= 1'b1;
                        state_reg      <= DONE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign diff       = diff_reg;
    assign borrow_out = borrow_out_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Directed bench for serial_subtractor_nbit: vector table plus handshake/reset sequences.
module tb_serial_subtractor_nbit;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    serial_subtractor_nbit #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .A          (A),
        .B          (B),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] exp_diff;
        logic       exp_bo;
        logic       exp_ov;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Starts an op, waits (bounded) for done; returns in the done cycle, #1 after E_N.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        A = a; B = b; borrow_in = bin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, bc, k, done_seen;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[4] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; A = '0; B = '0; borrow_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset diff", 32'(diff), 0);
        chk("reset borrow_out", 32'(borrow_out), 0);
        chk("reset overflow", 32'(overflow), 0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat, bc);
            chk("vec latency", 32'(lat), 8);
            chk("vec busy cycles", 32'(bc), 8);
            chk("vec busy in done cycle", 32'(busy), 0);
            chk("vec diff", 32'(diff), 32'(vecs[i].exp_diff));
            chk("vec borrow_out", 32'(borrow_out), 32'(vecs[i].exp_bo));
            chk("vec overflow", 32'(overflow), 32'(vecs[i].exp_ov));
            @(posedge clk); #1;
            chk("done one cycle", 32'(done), 0);
            $display("vec %0d: A=%02h B=%02h bin=%0d -> diff=%02h bo=%0d ov=%0d lat=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].bin, diff, borrow_out, overflow, lat);
        end

        // Back-to-back: start asserted during the DONE cycle.
        do_op(8'h10, 8'h0F, 1'b1, lat, bc);
        chk("b2b first diff", 32'(diff), 32'h00);
        chk("b2b first borrow_out", 32'(borrow_out), 0);
        A = 8'h03; B = 8'h05; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b accepted busy", 32'(busy), 1);
        chk("b2b done dropped", 32'(done), 0);
        chk("b2b diff held", 32'(diff), 32'h00);
        lat = 0;
        while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("b2b second latency", 32'(lat), 8);
        chk("b2b second diff", 32'(diff), 32'hFE);
        chk("b2b second borrow_out", 32'(borrow_out), 1);
        $display("b2b: diff=%02h bo=%0d lat=%0d", diff, borrow_out, lat);

        // Start pulsed while busy must be ignored.
        @(negedge clk);
        A = 8'h5A; B = 8'h3C; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        A = 8'hFF; B = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 3;
        while (!done && k < 20) begin @(posedge clk); #1; k++; end
        chk("ignore latency", 32'(k), 8);
        chk("ignore diff", 32'(diff), 32'h1E);
        @(posedge clk); #1;
        chk("ignore no second done", 32'(done), 0);
        chk("ignore idle", 32'(busy), 0);
        $display("ignore: diff=%02h lat=%0d", diff, k);

        // Reset mid-operation, with a nonzero held result beforehand.
        @(negedge clk);
        A = 8'h00; B = 8'h01; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("pre-reset diff", 32'(diff), 32'hFF);
        @(negedge clk);
        A = 8'h5A; B = 8'h3C; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", 32'(busy), 0);
        chk("async rst done", 32'(done), 0);
        chk("async rst diff", 32'(diff), 0);
        chk("async rst borrow_out", 32'(borrow_out), 0);
        @(negedge clk); rst = 1'b0;
        done_seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        chk("no activity after reset", 32'(done_seen), 0);
        do_op(8'h5A, 8'h3C, 1'b0, lat, bc);
        chk("post-reset latency", 32'(lat), 8);
        chk("post-reset diff", 32'(diff), 32'h1E);
        chk("post-reset overflow", 32'(overflow), 0);
        $display("reset: fresh diff=%02h lat=%0d", diff, lat);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_nbit.md
# serial_subtractor_Nbit

Bit-serial N-bit subtractor computing diff = A − B − borrow_in over N clock cycles, one bit per cycle, LSB first. It is the inverse-operation counterpart to the parallel ripple-carry N-bit adder in the combinational arithmetic library. It trades latency for area: one full-subtractor cell plus shift registers instead of N cells. It sits behind a simple start/busy/done handshake for use by sequential datapaths.

## Interface
- N, 8, operand and result width in bits; legal range N ≥ 2.

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  request; sampled on a rising edge, accepted only when busy = 0.
- A  input  N  minuend; captured on the accepting edge.
- B  input  N  subtrahend; captured on the accepting edge.
- borrow_in  input  1  initial borrow; captured on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse marking valid results.
- diff  output  N  result A − B − borrow_in, modulo 2^N.
- borrow_out  output  1  final borrow; 1 when the unsigned result is negative.
- overflow  output  1  two's-complement signed overflow of the subtraction.

## Operation
- States:
  - IDLE: reset state.
  - SHIFT: processing bits.
  - DONE: one cycle only.
- IDLE or DONE with start = 1:
  - Load the A and B shift registers.
  - Load the borrow register from borrow_in.
  - Clear the bit counter.
  - Go to SHIFT.
- IDLE or DONE with start = 0: go to (or stay in) IDLE.
- Each SHIFT cycle, with a = A_sh[0], b = B_sh[0], br = borrow register:
  - d = a ^ b ^ br
  - br_next = (~a & b) | (~(a ^ b) & br)
  - d shifts into the MSB of the result shift register.
  - A_sh and B_sh shift right by one.
  - The counter increments.
- When the counter reaches N−1, the same edge:
  - Loads diff from the completed result register.
  - Sets borrow_out = br_next.
  - Sets overflow = (A[N-1] ^ B[N-1]) & (A[N-1] ^ diff[N-1]), using the captured original operand MSBs and the new diff MSB.
  - Goes to DONE.
- diff, borrow_out and overflow hold their values until the next completion. They do not change on start.
- start while busy = 1 is ignored. Operands presented then are not captured.
- Reset mid-operation aborts immediately:
  - State returns to IDLE.
  - Partial results are discarded.
  - Outputs clear.

## Timing
- Reset values: busy = 0, done = 0, diff = 0, borrow_out = 0, overflow = 0, state = IDLE, counter = 0.
- Edge E0 accepts start. busy is high from after E0 through the cycle ending at edge E_N.
- Edges E1..E_N process bits 0..N−1.
- Results and done = 1 appear after E_N. Latency is N cycles from the accepting edge.
- done is high for exactly one cycle. busy = 0 during that cycle.
- start high during the DONE cycle is accepted at the next edge. Back-to-back throughput is one result per N+1 cycles.
- Counter width: $clog2(N), minimum 1 bit. Wrap-around never occurs, because the counter is cleared on each accept.

## Structure
- Shared package/header `arith_pkg`: state encodings IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2 (2'd3 is illegal and recovers to IDLE), plus a clog2 helper constant macro.
- One sub-module is natural: `full_subtractor` (inputs a, b, bin; outputs d, bout), purely combinational, instantiated once.
- Top level holds the FSM, the counter, three N-bit shift registers, the borrow flop and the output registers.

## Test plan
- N = 8, A = 0x5A, B = 0x3C, borrow_in = 0, start at E0 → busy high 8 cycles; after E8 done = 1 for one cycle; diff = 0x1E, borrow_out = 0, overflow = 0.
- A = 0x00, B = 0x01, borrow_in = 0 → diff = 0xFF, borrow_out = 1, overflow = 0.
- A = 0x80, B = 0x01, borrow_in = 0 → diff = 0x7F, borrow_out = 0, overflow = 1. Separately, A = 0x7F, B = 0xFF → diff = 0x80, borrow_out = 1, overflow = 1.
- A = 0x10, B = 0x0F, borrow_in = 1 → diff = 0x00, borrow_out = 0. Then start held high through the DONE cycle with A = 0x03, B = 0x05 → second op accepted; done again 8 cycles later with diff = 0xFE, borrow_out = 1.
- Start A = 0x5A, B = 0x3C, then pulse start with A = 0xFF, B = 0x00 at E3 (busy) → ignored; result is still 0x1E at E8.
- Start an op, assert rst at E4 → busy, done and diff drop to 0 asynchronously; after release, no done occurs until a new start; a fresh op completes correctly.
